// File: rtl/cache_data_ram_if.sv
// Access bus for cache_data_ram.
//   clr           : pulse, start clearing the whole array
//   busy          : a clear is in progress and accesses are ignored
//   re/raddr/rway : read request (byte address; the low lane bits are ignored)
//   rdata/rvalid  : read response
//   we/waddr/wway : write request (byte address; the low lane bits are ignored)
//   bsel/di       : byte-lane enables and write data
// The master modport is the cache controller side; the slave modport is the RAM side.
interface cache_data_ram_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13,
  parameter int WAYS   = 2
);
  localparam int LANES = DATA_W / 8;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic              clr;
  logic              busy;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [WAY_W-1:0]  rway;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WAY_W-1:0]  wway;
  logic [LANES-1:0]  bsel;
  logic [DATA_W-1:0] di;

  modport master (
    output clr, re, raddr, rway, we, waddr, wway, bsel, di,
    input  busy, rdata, rvalid
  );

  modport slave (
    input  clr, re, raddr, rway, we, waddr, wway, bsel, di,
    output busy, rdata, rvalid
  );
endinterface

// File: rtl/cache_data_ram.sv
// Byte-enabled, multi-way data array for the BIU caches. It has a built-in
// clear sequencer that zeroes every line after reset or when clr is pulsed.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of cache_data_ram_if (clear, read and write ports)
// Reads take 1 cycle, or 2 cycles when OUT_REG=1, and can be issued every cycle.
// When BYPASS=1, a write to the line being read in the same cycle forwards
// the written bytes to the read data. When BYPASS=0, the read returns the
// old data.
//
// state   | meaning
// IDLE    | accepting reads and writes
// CLEAR   | zeroing line ptr in every way, once per cycle; busy=1
module cache_data_ram #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 13,
  parameter int WAYS    = 2,
  parameter int OUT_REG = 0,
  parameter int BYPASS  = 1
) (
  input logic              clk,
  input logic              rst_n,
  cache_data_ram_if.slave  bus
);
  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int IDX_W  = ADDR_W - LANE_W;
  localparam int DEPTH  = 1 << IDX_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic              busy, rd_acc, wr_acc;
  logic [IDX_W-1:0]  ridx, widx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q1;
  logic              rvalid_q1;

  logic [DATA_W-1:0] mem [WAYS][DEPTH];

  assign ridx = bus.raddr[ADDR_W-1:LANE_W];
  assign widx = bus.waddr[ADDR_W-1:LANE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) ptr <= ptr + 1'b1;
      else                  ptr <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.clr) state_nxt = S_CLEAR;
      S_CLEAR: if (ptr == IDX_W'(DEPTH - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // If clr arrives in the same cycle as an access, the clear wins and the
  // access is dropped.
  always_comb begin
    busy   = 1'b0;
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    case (state)
      S_IDLE: begin
        rd_acc = bus.re && !bus.clr;
        wr_acc = bus.we && !bus.clr;
      end
      S_CLEAR: busy = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign bus.busy = busy;

  always_ff @(posedge clk) begin
    if (busy) begin
      for (int w = 0; w < WAYS; w++) mem[w][ptr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++)
        if (bus.bsel[i]) mem[bus.wway][widx][8*i +: 8] <= bus.di[8*i +: 8];
    end
  end

  // The array read returns the pre-edge contents, so the read is read-first
  // by default. The bypass then overlays the bytes being written.
  always_comb begin
    rd_word = mem[bus.rway][ridx];
    if (BYPASS != 0 && wr_acc && widx == ridx && bus.wway == bus.rway) begin
      for (int i = 0; i < LANES; i++)
        if (bus.bsel[i]) rd_word[8*i +: 8] = bus.di[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q1 <= 1'b0;
      rdata_q1  <= '0;
    end else begin
      rvalid_q1 <= rd_acc;
      if (rd_acc) rdata_q1 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] rdata_q2;
      logic              rvalid_q2;
      logic              fwd;

      // A read still in flight when a clear starts is dropped, so rvalid
      // never rises while busy.
      assign fwd = rvalid_q1 && (state_nxt == S_IDLE);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_q2 <= 1'b0;
          rdata_q2  <= '0;
        end else begin
          rvalid_q2 <= fwd;
          if (fwd) rdata_q2 <= rdata_q1;
        end
      end

      assign bus.rdata  = rdata_q2;
      assign bus.rvalid = rvalid_q2;
    end else begin : g_noreg
      assign bus.rdata  = rdata_q1;
      assign bus.rvalid = rvalid_q1;
    end
  endgenerate
endmodule

// File: tb/tb_cache_data_ram.sv
module tb_cache_data_ram;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b0, re = 1'b0, we = 1'b0;
  logic [12:0] raddr = '0, waddr = '0;
  logic        rway = 1'b0, wway = 1'b0;
  logic [7:0]  bsel = '0;
  logic [63:0] di = '0;

  cache_data_ram_if #(.DATA_W(64), .ADDR_W(13), .WAYS(2)) b0 ();
  cache_data_ram_if #(.DATA_W(64), .ADDR_W(13), .WAYS(2)) b1 ();

  assign b0.clr = clr;   assign b1.clr = clr;
  assign b0.re = re;     assign b1.re = re;
  assign b0.raddr = raddr; assign b1.raddr = raddr;
  assign b0.rway = rway; assign b1.rway = rway;
  assign b0.we = we;     assign b1.we = we;
  assign b0.waddr = waddr; assign b1.waddr = waddr;
  assign b0.wway = wway; assign b1.wway = wway;
  assign b0.bsel = bsel; assign b1.bsel = bsel;
  assign b0.di = di;     assign b1.di = di;

  // dut0: latency 1 with bypass; dut1: latency 2, read-first
  cache_data_ram #(.DATA_W(64), .ADDR_W(13), .WAYS(2), .OUT_REG(0), .BYPASS(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  cache_data_ram #(.DATA_W(64), .ADDR_W(13), .WAYS(2), .OUT_REG(1), .BYPASS(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  typedef struct {
    int          due;
    logic [63:0] d;
  } exp_t;

  exp_t        q0[$], q1[$];
  exp_t        e0, e1;
  logic [63:0] mdl [2][DEPTH];
  bit          mdl_busy = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each expected read must show up exactly at its due cycle,
  // and rvalid must stay low at every other cycle.
  always @(negedge clk) begin
    if (q0.size() != 0 && q0[0].due == cyc) begin
      e0 = q0.pop_front();
      total++;
      if (b0.rvalid !== 1'b1 || b0.rdata !== e0.d) begin
        bad++;
        $display("FAIL rd0 cyc=%0d got v=%b d=%h exp v=1 d=%h", cyc, b0.rvalid, b0.rdata, e0.d);
      end
    end else if (b0.rvalid !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL rvalid0 cyc=%0d got %b exp 0", cyc, b0.rvalid);
    end
    if (q1.size() != 0 && q1[0].due == cyc) begin
      e1 = q1.pop_front();
      total++;
      if (b1.rvalid !== 1'b1 || b1.rdata !== e1.d) begin
        bad++;
        $display("FAIL rd1 cyc=%0d got v=%b d=%h exp v=1 d=%h", cyc, b1.rvalid, b1.rdata, e1.d);
      end
    end else if (b1.rvalid !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL rvalid1 cyc=%0d got %b exp 0", cyc, b1.rvalid);
    end
  end

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int l = 0; l < DEPTH; l++) mdl[w][l] = '0;
  endtask

  task automatic drive(input logic c, input logic r, input int rl, input int rw,
                       input logic w, input int wl, input int ww,
                       input logic [7:0] bs, input logic [63:0] d);
    logic [63:0] old, byp;
    bit acc;
    clr   = c;
    re    = r;
    raddr = 13'(rl * 8 + int'($urandom_range(0, 7)));
    rway  = rw[0];
    we    = w;
    waddr = 13'(wl * 8 + int'($urandom_range(0, 7)));
    wway  = ww[0];
    bsel  = bs;
    di    = d;
    acc   = !mdl_busy && !c;
    if (acc && r) begin
      old = mdl[rw][rl];
      byp = old;
      if (w && wl == rl && ww == rw)
        for (int i = 0; i < 8; i++) if (bs[i]) byp[8*i +: 8] = d[8*i +: 8];
      q0.push_back('{cyc + 1, byp});
      q1.push_back('{cyc + 2, old});
    end
    if (acc && w)
      for (int i = 0; i < 8; i++) if (bs[i]) mdl[ww][wl][8*i +: 8] = d[8*i +: 8];
    if (c && !mdl_busy) clear_model();
    @(posedge clk);
    #1;
    clr = 1'b0;
    re  = 1'b0;
    we  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 64'h0);
  endtask

  task automatic test_reset();
    int n;
    clear_model();
    mdl_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (b0.busy !== 1'b1 || b0.rvalid !== 1'b0 || b0.rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset0 got busy=%b rvalid=%b rdata=%h exp 1 0 0", b0.busy, b0.rvalid, b0.rdata);
    end
    total++;
    if (b1.busy !== 1'b1 || b1.rvalid !== 1'b0 || b1.rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset1 got busy=%b rvalid=%b rdata=%h exp 1 0 0", b1.busy, b1.rvalid, b1.rdata);
    end
    rst_n = 1'b1;
    n = 0;
    while (b0.busy === 1'b1 && n < 3000) begin
      n++;
      @(posedge clk);
      #1;
    end
    total++;
    if (n != DEPTH || b1.busy !== 1'b0) begin
      bad++;
      $display("FAIL init_busy got %0d cycles (busy1=%b) exp %0d", n, b1.busy, DEPTH);
    end
    mdl_busy = 1'b0;
    drive(0, 1, 0, 0, 0, 0, 0, 8'h00, 64'h0);
    drive(0, 1, 1023, 1, 0, 0, 0, 8'h00, 64'h0);
    drive(0, 1, 517, 1, 0, 0, 0, 8'h00, 64'h0);
    idle(3);
  endtask

  task automatic test_partial_write();
    drive(0, 0, 0, 0, 1, 5, 1, 8'h0F, 64'h1122334455667788);
    drive(0, 1, 5, 1, 1, 6, 0, 8'h00, 64'hFFFFFFFFFFFFFFFF);
    drive(0, 1, 6, 0, 0, 0, 0, 8'h00, 64'h0);
    drive(0, 1, 5, 1, 0, 0, 0, 8'h00, 64'h0);
    idle(3);
    total++;
    if (b0.rdata !== 64'h0000000055667788) begin
      bad++;
      $display("FAIL partial0 got %h exp %h", b0.rdata, 64'h0000000055667788);
    end
    total++;
    if (b1.rdata !== 64'h0000000055667788) begin
      bad++;
      $display("FAIL partial1 got %h exp %h", b1.rdata, 64'h0000000055667788);
    end
  endtask

  task automatic test_bypass();
    drive(0, 0, 0, 0, 1, 7, 0, 8'hFF, 64'h0123456789ABCDEF);
    drive(0, 1, 7, 0, 1, 7, 0, 8'hF0, 64'hAAAAAAAAAAAAAAAA);
    total++;
    if (b0.rdata !== 64'hAAAAAAAA89ABCDEF) begin
      bad++;
      $display("FAIL bypass0 got %h exp %h", b0.rdata, 64'hAAAAAAAA89ABCDEF);
    end
    idle(1);
    total++;
    if (b1.rdata !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL readfirst1 got %h exp %h", b1.rdata, 64'h0123456789ABCDEF);
    end
    drive(0, 1, 7, 0, 1, 7, 1, 8'hFF, 64'h5555555555555555);
    drive(0, 1, 7, 1, 0, 0, 0, 8'h00, 64'h0);
    idle(3);
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 1, 1, 0, 8'hFF, 64'h1111111111111111);
    drive(0, 0, 0, 0, 1, 2, 0, 8'hFF, 64'h2222222222222222);
    drive(0, 0, 0, 0, 1, 3, 0, 8'hFF, 64'h3333333333333333);
    drive(0, 1, 1, 0, 0, 0, 0, 8'h00, 64'h0);
    drive(0, 1, 2, 0, 0, 0, 0, 8'h00, 64'h0);
    drive(0, 1, 3, 0, 0, 0, 0, 8'h00, 64'h0);
    idle(4);
    total++;
    if (b0.rdata !== 64'h3333333333333333 || b1.rdata !== 64'h3333333333333333) begin
      bad++;
      $display("FAIL hold got %h/%h exp %h", b0.rdata, b1.rdata, 64'h3333333333333333);
    end
  endtask

  task automatic test_clear();
    int n;
    drive(0, 0, 0, 0, 1, 9, 1, 8'hFF, 64'h9999999999999999);
    drive(0, 0, 0, 0, 1, 2, 0, 8'hFF, 64'h2020202020202020);
    // clr with we and re in the same cycle: the clear wins
    drive(1, 1, 9, 1, 1, 12, 0, 8'hFF, 64'hC0C0C0C0C0C0C0C0);
    mdl_busy = 1'b1;
    n = 0;
    while (b0.busy === 1'b1 && n < 3000) begin
      n++;
      if (n == 10) drive(1, 1, 2, 0, 1, 2, 0, 8'hFF, 64'hDEADBEEFDEADBEEF);
      else         idle(1);
    end
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("FAIL clr_busy got %0d cycles exp %0d", n, DEPTH);
    end
    mdl_busy = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int l = 0; l < DEPTH; l++) drive(0, 1, l, w, 0, 0, 0, 8'h00, 64'h0);
    idle(3);
  endtask

  task automatic test_reset_mid();
    int n;
    drive(0, 0, 0, 0, 1, 4, 1, 8'hFF, 64'h4444444444444444);
    drive(0, 1, 4, 1, 0, 0, 0, 8'h00, 64'h0);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    clear_model();
    mdl_busy = 1'b1;
    #1;
    total++;
    if (b0.rvalid !== 1'b0 || b1.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL inflight got rvalid %b/%b exp 0/0", b0.rvalid, b1.rvalid);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(500);
    rst_n = 1'b0;
    #1;
    total++;
    if (b0.busy !== 1'b1 || b1.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got %b/%b exp 1/1", b0.busy, b1.busy);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (b0.busy === 1'b1 && n < 3000) begin
      n++;
      idle(1);
    end
    total++;
    if (n != DEPTH || b1.busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_busy got %0d cycles (busy1=%b) exp %0d", n, b1.busy, DEPTH);
    end
    mdl_busy = 1'b0;
    drive(0, 1, 4, 1, 0, 0, 0, 8'h00, 64'h0);
    drive(0, 1, 500, 0, 0, 0, 0, 8'h00, 64'h0);
    drive(0, 1, 1023, 1, 0, 0, 0, 8'h00, 64'h0);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_partial_write();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end
endmodule
